uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and write sequencer sitting directly upstream of the UART serial transmitter. It accepts bytes from the host bus through a valid/ready push port and stores them in a power-of-two circular FIFO. It drains the FIFO into the transmitter one byte at a time, honouring the transmitter's busy flag and its rule that the write strobe must fall after every write. The host can therefore queue a burst without polling the transmitter.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `LEVEL_WIDTH`, $clog2(DEPTH)+1: width of `level_o`. Derived; never overridden.

Ports:
- `clock_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset. One clock domain only.
- `wr_data_i`  in  8  byte to queue.
- `wr_valid_i`  in  1  push request.
- `wr_ready_o`  out  1  FIFO not full.
- `flush_i`  in  1  synchronous FIFO clear.
- `level_o`  out  LEVEL_WIDTH  stored entry count, 0..DEPTH.
- `empty_o`  out  1  level_o == 0.
- `overflow_o`  out  1  sticky: push attempted while full.
- `tx_data_o`  out  8  to transmitter `data_i`.
- `tx_write_o`  out  1  to transmitter `write_i`.
- `tx_busy_i`  in  1  from transmitter `busy_o`.

## Operation
- Storage: DEPTH×8 array with read and write pointers of $clog2(DEPTH) bits each. Pointers wrap modulo DEPTH. `level_o` is a separate registered counter.
- Push: `wr_valid_i && wr_ready_o` at a clock edge writes `wr_data_i` at the write pointer, then increments the write pointer and the level. `wr_ready_o = (level_o != DEPTH)` is derived from registers only.
- Push while full: the byte is dropped and the FIFO is unchanged. This holds even if a pop occurs on the same edge.
- Drain FSM states:
  - IDLE: if `!empty_o && !tx_busy_i`, load `tx_data_o` from the head, set `tx_write_o=1` and go to STROBE.
  - STROBE: clear `tx_write_o`, pop the head (read pointer +1, level −1) and go to SETTLE.
  - SETTLE: unconditional return to IDLE. This guarantees `tx_write_o` stays low for at least 2 cycles between strobes.
- Push and pop on the same edge: the level is unchanged and both pointers advance.
- Flush: `flush_i` sets pointers and level to 0. It does not affect the FSM, so a byte already in STROBE is still popped, with the pop suppressed so the level stays 0. `tx_data_o` holds its value. Flush takes priority over a push on the same edge.
- Reset mid-transfer: all state clears at once and any queued bytes are lost. While the transmitter is still busy after its own reset, the FSM waits in IDLE.
- Reset values:
  - `tx_write_o=0`, `tx_data_o=8'h00`.
  - `level_o=0`, `empty_o=1`, `wr_ready_o=1`, `overflow_o=0`.
  - FSM in IDLE, both pointers 0.

## Timing
- Push accepted at edge N: `empty_o` falls after edge N. With `tx_busy_i` low, `tx_write_o` rises after edge N+1 and falls after edge N+2.
- The transmitter captures the byte on the edge where `tx_write_o` is high and raises busy after that edge. By the time the FSM returns to IDLE it samples busy high.
- Back-to-back bytes: the next strobe issues on the first IDLE cycle that sees `tx_busy_i` low.
- All outputs are registered except `wr_ready_o` and `empty_o`, which are decoded from `level_o`.

## Configuration
- `UART_TX_FIFO_OVERFLOW_EN` defined:
  - `overflow_o` sets when `wr_valid_i && !wr_ready_o` occurs at an edge.
  - It clears only on reset or `flush_i`.
- Not defined: `overflow_o` is tied to 0 and no register is built. The port is always present.

## Structure
- Shared package/include `uart_pkg`:
  - FSM state encodings (IDLE/STROBE/SETTLE).
  - The byte width constant.
- One sub-module, `uart_fifo_mem`: DEPTH×8 storage with one write port and an asynchronous read port. Pointer, level and FSM logic stay in `uart_tx_fifo`.

## Test plan
- Single byte, `tx_busy_i` low: push 8'hA5 at edge 0 → `tx_write_o` high exactly one cycle after edge 1, `tx_data_o=8'hA5`, `level_o` back to 0 after edge 2.
- Burst with a transmitter model (busy 100 cycles per byte): push 8'h01..8'h05 on consecutive cycles → five strobes in order 01..05, each in the first IDLE cycle with busy low, `tx_write_o` never high two cycles running.
- Fill to DEPTH=16 with busy held high: 16 pushes → `wr_ready_o=0`, `level_o=16`; 17th push 8'hFF is dropped, `overflow_o=1` if macro defined else 0. Pointer wrap is checked by draining, then refilling 16 more.
- Push and pop on the same edge at level 16: the push is rejected and the level becomes 15. At level 3: the level stays 3.
- Flush with 4 queued entries while in STROBE: `level_o=0`, `empty_o=1`, the in-flight byte is still delivered once and no further strobes follow.
- Reset asserted asynchronously mid-burst: outputs take their reset values immediately. After release, with `tx_busy_i` high for 12 bit times, no strobe until busy falls.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width and drain FSM states.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STROBE = 2'd1,
    TX_SETTLE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x byte storage for the transmit FIFO: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [BYTE_W-1:0] rd_data_c_o
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_data_c_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus write sequencer feeding the UART transmitter one strobe at a time.
// Optional sticky overflow flag is built only when UART_TX_FIFO_OVERFLOW_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [BYTE_W-1:0]      wr_data_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic                   flush_i,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   empty_o,
  output logic                   overflow_o,
  output logic [BYTE_W-1:0]      tx_data_o,
  output logic                   tx_write_o,
  input  logic                   tx_busy_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [BYTE_W-1:0]      head_data_c;
  tx_state_e              state_q;
  logic                   push_c;
  logic                   pop_c;

  assign wr_ready_o = (level_q != LEVEL_WIDTH'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;

  // Flush wins over both push and pop; the empty guard covers a flush landing on the load edge.
  assign push_c = wr_valid_i && wr_ready_o && !flush_i;
  assign pop_c  = (state_q == TX_STROBE) && !empty_o && !flush_i;

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_mem (
    .clock_i    (clock_i),
    .we_i       (push_c),
    .waddr_i    (wr_ptr_q),
    .wdata_i    (wr_data_i),
    .raddr_i    (rd_ptr_q),
    .rd_data_c_o(head_data_c)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LEVEL_WIDTH'(push_c) - LEVEL_WIDTH'(pop_c);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Drain sequencer: SETTLE keeps the strobe low for two cycles between writes.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= TX_IDLE;
      tx_write_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (!empty_o && !tx_busy_i) begin
            tx_data_o  <= head_data_c;
            tx_write_o <= 1'b1;
            state_q    <= TX_STROBE;
          end
        end
        TX_STROBE: begin
          tx_write_o <= 1'b0;
          state_q    <= TX_SETTLE;
        end
        TX_SETTLE: begin
          state_q <= TX_IDLE;
        end
        default: begin
          tx_write_o <= 1'b0;
          state_q    <= TX_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q;
    if (flush_i) begin
      overflow_d = 1'b0;
    end else if (wr_valid_i && !wr_ready_o) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow_o = overflow_q;
`else
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: behavioural transmitter model plus queue-based reference.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = 5;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          flush;
  logic [LW-1:0] level;
  logic          empty;
  logic          overflow;
  logic [7:0]    tx_data;
  logic          tx_write;
  logic          tx_busy;

  int errors = 0;
  int checks = 0;

  // Transmitter model state
  int         cyc = 0;
  bit         busy_hold = 1'b0;
  int         busy_len = 2;
  int         busy_cnt = 0;
  int         last_fall = 0;
  bit         prev_write = 1'b0;
  int         double_high = 0;
  logic [7:0] rx_q[$];
  int         gap_q[$];

  uart_tx_fifo dut (
    .clock_i   (clk),
    .reset_i   (rst),
    .wr_data_i (wr_data),
    .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready),
    .flush_i   (flush),
    .level_o   (level),
    .empty_o   (empty),
    .overflow_o(overflow),
    .tx_data_o (tx_data),
    .tx_write_o(tx_write),
    .tx_busy_i (tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter: captures each strobe, stays busy busy_len cycles, records gap from busy fall.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (tx_write === 1'b1) begin
      rx_q.push_back(tx_data);
      gap_q.push_back(cyc - last_fall);
      if (prev_write) double_high++;
      busy_cnt = busy_len;
    end
    prev_write = (tx_write === 1'b1);
    if (busy_hold || busy_cnt > 0) begin
      tx_busy = 1'b1;
      if (busy_cnt > 0) busy_cnt--;
    end else begin
      if (tx_busy === 1'b1) last_fall = cyc;
      tx_busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while ((empty !== 1'b1 || tx_busy !== 1'b0 || tx_write !== 1'b0) && n < 2000) begin
      step();
      n++;
    end
    repeat (3) step();
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL idle_wait timeout level=%0d busy=%0b", level, tx_busy); end
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (tx_write !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (tx_write !== 1'b1) begin errors++; $display("FAIL %s strobe_timeout got=%0b exp=1", tag, tx_write); end
  endtask

  task automatic wait_rx(input int target, input int budget);
    int n;
    n = 0;
    while (rx_q.size() < target && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL reset_tx_write got=%0b exp=0", tx_write); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int s;
    busy_hold = 1'b0;
    busy_len  = 3;
    idle_wait();
    s = rx_q.size();
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got=%0b exp=0", empty); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level1 got=%0d exp=1", level); end
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL single_write_e0 got=%0b exp=0", tx_write); end
    step();
    checks++; if (tx_write !== 1'b1) begin errors++; $display("FAIL single_write_e1 got=%0b exp=1", tx_write); end
    checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", tx_data); end
    step();
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL single_write_e2 got=%0b exp=0", tx_write); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL single_level0 got=%0d exp=0", level); end
    checks++; if (rx_q.size() != s + 1) begin errors++; $display("FAIL single_count got=%0d exp=%0d", rx_q.size() - s, 1); end
  endtask

  task automatic test_burst();
    int s;
    busy_hold = 1'b0;
    busy_len  = 100;
    idle_wait();
    s = rx_q.size();
    for (int i = 1; i <= 5; i++) begin
      wr_data  = 8'(i);
      wr_valid = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    wait_rx(s + 5, 1500);
    checks++; if (rx_q.size() != s + 5) begin errors++; $display("FAIL burst_count got=%0d exp=5", rx_q.size() - s); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_q[s+i] !== 8'(i + 1)) begin errors++; $display("FAIL burst_byte%0d got=%h exp=%h", i, rx_q[s+i], 8'(i + 1)); end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (gap_q[s+i] != 1) begin errors++; $display("FAIL burst_gap%0d got=%0d exp=1", i, gap_q[s+i]); end
    end
    checks++; if (double_high != 0) begin errors++; $display("FAIL burst_double_high got=%0d exp=0", double_high); end
  endtask

  task automatic test_fill();
    int s;
    logic [7:0] q[$];
    logic [7:0] b;
    for (int pass = 0; pass < 2; pass++) begin
      busy_hold = 1'b0;
      busy_len  = 2;
      idle_wait();
      busy_hold = 1'b1;
      step();
      s = rx_q.size();
      q.delete();
      for (int i = 0; i < 16; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        wr_data  = b;
        wr_valid = 1'b1;
        step();
      end
      wr_valid = 1'b0;
      checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill%0d_ready got=%0b exp=0", pass, wr_ready); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill%0d_level got=%0d exp=16", pass, level); end
      if (pass == 0) begin
        wr_data  = 8'hFF;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_drop_level got=%0d exp=16", level); end
        checks++; if (overflow !== OVF_EN) begin errors++; $display("FAIL fill_overflow got=%0b exp=%0b", overflow, OVF_EN); end
        // push on the pop edge while full: push dropped, level drops by one
        busy_hold = 1'b0;
        wait_strobe("fill_pushpop");
        busy_hold = 1'b1;
        wr_data   = 8'($urandom);
        wr_valid  = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL fill_pushpop_level got=%0d exp=15", level); end
      end
      busy_hold = 1'b0;
      wait_rx(s + 16, 1000);
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rx_q[s+i] !== q[i]) begin errors++; $display("FAIL fill%0d_byte%0d got=%h exp=%h", pass, i, rx_q[s+i], q[i]); end
      end
      checks++; if (overflow !== OVF_EN) begin errors++; $display("FAIL fill%0d_overflow_sticky got=%0b exp=%0b", pass, overflow, OVF_EN); end
    end
  endtask

  task automatic test_same_edge();
    int s;
    logic [7:0] q[$];
    logic [7:0] b;
    busy_hold = 1'b0;
    busy_len  = 2;
    idle_wait();
    busy_hold = 1'b1;
    step();
    s = rx_q.size();
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      wr_data  = b;
      wr_valid = 1'b1;
      step();
    end
    wr_valid  = 1'b0;
    busy_hold = 1'b0;
    wait_strobe("same_edge");
    busy_hold = 1'b1;
    b = 8'($urandom);
    q.push_back(b);
    wr_data  = b;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL same_edge_level got=%0d exp=3", level); end
    busy_hold = 1'b0;
    wait_rx(s + 4, 500);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_q[s+i] !== q[i]) begin errors++; $display("FAIL same_edge_byte%0d got=%h exp=%h", i, rx_q[s+i], q[i]); end
    end
  endtask

  task automatic test_random();
    int s, mlevel, bad_level, bad_ready;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic v, acc, was_strobe;
    busy_hold = 1'b0;
    busy_len  = 2;
    idle_wait();
    s = rx_q.size();
    mlevel = 0;
    bad_level = 0;
    bad_ready = 0;
    for (int k = 0; k < 400; k++) begin
      if ((k % 50) == 0) busy_len = int'($urandom_range(0, 6));
      busy_hold  = (k >= 100 && k < 160);
      v          = ($urandom_range(0, 2) != 0);
      b          = 8'($urandom);
      wr_valid   = v;
      wr_data    = b;
      was_strobe = (tx_write === 1'b1);
      acc        = v && (mlevel != int'(DEPTH));
      step();
      if (acc) exp_q.push_back(b);
      mlevel = mlevel + int'(acc) - int'(was_strobe);
      checks++;
      if (level !== LW'(mlevel)) begin
        errors++;
        if (bad_level < 5) $display("FAIL random_level k=%0d got=%0d exp=%0d", k, level, mlevel);
        bad_level++;
      end
      checks++;
      if (wr_ready !== (mlevel != int'(DEPTH))) begin
        errors++;
        if (bad_ready < 5) $display("FAIL random_ready k=%0d got=%0b exp=%0b", k, wr_ready, mlevel != int'(DEPTH));
        bad_ready++;
      end
    end
    wr_valid  = 1'b0;
    busy_hold = 1'b0;
    busy_len  = 2;
    wait_rx(s + exp_q.size(), 2000);
    checks++; if (rx_q.size() != s + exp_q.size()) begin errors++; $display("FAIL random_count got=%0d exp=%0d", rx_q.size() - s, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (rx_q[s+i] !== exp_q[i]) begin errors++; $display("FAIL random_byte%0d got=%h exp=%h", i, rx_q[s+i], exp_q[i]); end
    end
    checks++; if (double_high != 0) begin errors++; $display("FAIL random_double_high got=%0d exp=0", double_high); end
  endtask

  task automatic test_flush();
    int s;
    logic [7:0] q[$];
    logic [7:0] b;
    busy_hold = 1'b0;
    busy_len  = 2;
    idle_wait();
    busy_hold = 1'b1;
    step();
    s = rx_q.size();
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      wr_data  = b;
      wr_valid = 1'b1;
      step();
    end
    wr_valid  = 1'b0;
    busy_hold = 1'b0;
    wait_strobe("flush");
    busy_hold = 1'b1;
    flush     = 1'b1;
    wr_valid  = 1'b1;
    wr_data   = 8'($urandom);
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%0b exp=1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got=%0b exp=0", overflow); end
    busy_hold = 1'b0;
    repeat (40) step();
    checks++; if (rx_q.size() != s + 1) begin errors++; $display("FAIL flush_strobes got=%0d exp=1", rx_q.size() - s); end
    checks++; if (rx_q[s] !== q[0]) begin errors++; $display("FAIL flush_inflight got=%h exp=%h", rx_q[s], q[0]); end
    checks++; if (tx_data !== q[0]) begin errors++; $display("FAIL flush_data_hold got=%h exp=%h", tx_data, q[0]); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL flush_level_after got=%0d exp=0", level); end
  endtask

  task automatic test_reset_mid();
    int s;
    logic [7:0] b;
    busy_hold = 1'b0;
    busy_len  = 4;
    idle_wait();
    for (int i = 0; i < 6; i++) begin
      wr_data  = 8'($urandom);
      wr_valid = 1'b1;
      step();
    end
    wr_valid = 1'b0;
    wait_strobe("reset_mid");
    #1;
    rst       = 1'b1;
    busy_hold = 1'b1;
    #1;
    checks++; if (tx_write !== 1'b0) begin errors++; $display("FAIL rmid_tx_write got=%0b exp=0", tx_write); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rmid_tx_data got=%h exp=00", tx_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rmid_level got=%0d exp=0", level); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got=%0b exp=1", empty); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got=%0b exp=1", wr_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow got=%0b exp=0", overflow); end
    step();
    step();
    rst = 1'b0;
    step();
    s = rx_q.size();
    b = 8'($urandom);
    wr_data  = b;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    repeat (12) step();
    checks++; if (rx_q.size() != s) begin errors++; $display("FAIL rmid_no_strobe got=%0d exp=0", rx_q.size() - s); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL rmid_level_held got=%0d exp=1", level); end
    busy_hold = 1'b0;
    wait_rx(s + 1, 50);
    checks++; if (rx_q.size() != s + 1) begin errors++; $display("FAIL rmid_strobe_count got=%0d exp=1", rx_q.size() - s); end
    checks++; if (rx_q[s] !== b) begin errors++; $display("FAIL rmid_byte got=%h exp=%h", rx_q[s], b); end
    checks++; if (gap_q[s] != 1) begin errors++; $display("FAIL rmid_gap got=%0d exp=1", gap_q[s]); end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    flush    = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_same_edge();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
